// File: rtl/isif_axis_fifo.sv
`default_nettype none
// ============================================================================
// Module   : isif_axis_fifo
// Purpose  : Buffers an AXI4-Stream slave beat stream in a first-word-fall-
//            through FIFO. It presents the head beat on the ISIF pop-style port.
// Revision : 1.0 - initial release
// ============================================================================
module isif_axis_fifo #(
    parameter int TRANS_BYTE_SIZE = 8,
    parameter int TRANS_BITS      = 64,
    parameter int DEPTH           = 16,
    parameter int ADDR_BITS       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [TRANS_BITS-1:0]      s_axis_tdata,
    input  logic [TRANS_BYTE_SIZE-1:0] s_axis_tstrb,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tuser,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [TRANS_BITS-1:0]      dout_isif_data,
    output logic [TRANS_BYTE_SIZE-1:0] dout_isif_strb,
    output logic                       dout_isif_last,
    output logic                       dout_isif_user,
    output logic                       dout_isif_empty_n,
    input  logic                       din_isif_read,
    output logic [ADDR_BITS:0]         fill_level,
    output logic [15:0]                frame_cnt,
    output logic                       underflow_err
);

    localparam int               c_ENTRY_W = TRANS_BITS + TRANS_BYTE_SIZE + 2;
    localparam logic [ADDR_BITS:0] c_DEPTH = (ADDR_BITS + 1)'(DEPTH);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 r_tready;
    logic [15:0]          r_frame_cnt;
    logic                 r_underflow;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty_n;
    logic [ADDR_BITS:0]   w_count_next;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_empty_n = (r_count != '0);
    assign w_push    = s_axis_tvalid && r_tready;
    assign w_pop     = din_isif_read && w_empty_n;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Storage is never reset: only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_axis_tdata, s_axis_tstrb, s_axis_tlast, s_axis_tuser};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_tready    <= 1'b0;
            r_frame_cnt <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            // Registered from the next count so tready has no path from read/tvalid.
            r_tready <= (w_count_next != c_DEPTH);
            if (w_push && s_axis_tlast) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (din_isif_read && !w_empty_n) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign w_head            = r_mem[r_rd_ptr];
    assign dout_isif_data    = w_head[c_ENTRY_W-1 -: TRANS_BITS];
    assign dout_isif_strb    = w_head[2 +: TRANS_BYTE_SIZE];
    assign dout_isif_last    = w_head[1];
    assign dout_isif_user    = w_head[0];
    assign dout_isif_empty_n = w_empty_n;
    assign s_axis_tready     = r_tready;
    assign fill_level        = r_count;
    assign frame_cnt         = r_frame_cnt;
    assign underflow_err     = r_underflow;

endmodule
`default_nettype wire

// File: doc/isif_axis_fifo.md
Name: isif_axis_fifo

Overview:
Input-stream interface (ISIF) producer. It accepts an AXI4-Stream slave beat stream from the DMA and buffers it in a first-word-fall-through FIFO. It presents the buffered beats on the FIFO-style ISIF port that the convolution core consumes: data, last, strb and user, with empty_n as "data available" and read as "pop". Data bytes pass through unchanged; endian swapping stays in the core.

Parameters:
TRANS_BYTE_SIZE, 8, number of byte lanes; width of strb.
TRANS_BITS, 64, data width; must equal 8*TRANS_BYTE_SIZE.
DEPTH, 16, FIFO entries; power of two, at least 2.
ADDR_BITS, 4, log2(DEPTH).

Ports:
clk  in  1  single clock; all logic on posedge.
reset  in  1  asynchronous, active-high reset.
s_axis_tdata  in  TRANS_BITS  stream data.
s_axis_tstrb  in  TRANS_BYTE_SIZE  byte strobes.
s_axis_tlast  in  1  end of transfer.
s_axis_tuser  in  1  sideband (start-of-frame).
s_axis_tvalid  in  1  beat valid.
s_axis_tready  out  1  FIFO can accept a beat.
dout_isif_data  out  TRANS_BITS  head-of-FIFO data.
dout_isif_strb  out  TRANS_BYTE_SIZE  head strb.
dout_isif_last  out  1  head last.
dout_isif_user  out  1  head user.
dout_isif_empty_n  out  1  head entry valid.
din_isif_read  in  1  core pops the head.
fill_level  out  ADDR_BITS+1  entries stored, 0..DEPTH.
frame_cnt  out  16  count of tlast beats accepted, wrapping.
underflow_err  out  1  sticky: read asserted while empty.

Behaviour:
- Storage: DEPTH x (TRANS_BITS + TRANS_BYTE_SIZE + 2) entries. Pointers wr_ptr and rd_ptr are ADDR_BITS wide. count is a register of width ADDR_BITS+1.
- Push condition: push = s_axis_tvalid && s_axis_tready. On push, the beat is written at wr_ptr and wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop condition: pop = din_isif_read && dout_isif_empty_n. On pop, rd_ptr increments with the same wrap.
- count_next:
  - count+1 if push && !pop
  - count-1 if pop && !push
  - count otherwise
- Flags:
  - fill_level = count.
  - dout_isif_empty_n = (count != 0), driven from the register.
  - s_axis_tready is a register, updated each cycle to (count_next != DEPTH). There is no combinational path from din_isif_read or s_axis_tvalid to s_axis_tready.
- Fall-through: dout_isif_* always reflect the entry at rd_ptr, with an asynchronous memory read.
  - Latency from push into an empty FIFO to empty_n=1 is 1 cycle.
  - The next entry is visible on the cycle after a pop.
  - dout_isif_* contents are don't-care while empty_n=0.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, tready=0, so only the pop occurs; tready rises on the next cycle.
  - When empty, the pop is ignored; the push lands and empty_n rises on the next cycle.
- Read while empty: no pointer change. underflow_err is set to 1 and holds until reset.
- frame_cnt increments on push && s_axis_tlast and wraps 0xFFFF -> 0.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers, count, frame_cnt and underflow_err clear to 0.
  - empty_n=0 and s_axis_tready=0.
  - Stored data is discarded; memory contents are not cleared.
  - s_axis_tready goes to 1 on the first posedge clk after reset deasserts.
- No state machine beyond the pointer/count registers. The block never drops, duplicates or reorders beats.

Test Plan:
1. Reset then a single beat: tdata=0x0102030405060708, strb=0xFF, last=1, user=1 pushed in cycle N -> empty_n=1 in N+1 with identical data/strb/last/user; frame_cnt=1. Pulse read -> empty_n=0, fill_level=0.
2. Fill: tvalid held high with the core never reading, data = beat index 0..20 -> exactly 16 beats accepted; tready=0 from the cycle after the 16th push; fill_level=16. Then pop 16 -> data 0..15 appear in order.
3. Full with simultaneous push attempt and pop: FIFO full, tvalid=1, read=1 -> one pop, no push, tready=1 next cycle, fill_level=15. The following push is the 17th beat and lands correctly.
4. Streaming with read and tvalid both held high for 100 beats -> after the 1-cycle fill, throughput is 1 beat/cycle; fill_level stays at 1; output sequence equals input sequence.
5. read=1 while empty for 3 cycles -> underflow_err=1 and stays 1; pointers unchanged; the next pushed beat is output correctly.
6. Assert reset asynchronously (between clock edges) with 7 entries stored and frame_cnt=3 -> immediately fill_level=0, empty_n=0, tready=0, frame_cnt=0, underflow_err=0. After release, tready=1 on the first edge and a new beat passes with 1-cycle latency.
